// File: rtl/mux_in_arbiter.sv
// Two-channel valid/ready front end for a 2:1 select mux: one-word buffer per channel, round-robin grant, valid/ready output.
// Optional per-channel grant counters are enabled by defining MUX_ARB_CNT_EN.
module mux_in_arbiter #(
    parameter int DW    = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [DW-1:0]    req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DW-1:0]    req1_data,
    output logic             req1_ready,
    output logic [DW-1:0]    mux_in0,
    output logic [DW-1:0]    mux_in1,
    output logic             mux_sel,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      full_reg;
    logic [1:0]      valid_vec;
    logic [1:0]      accept;
    logic [1:0]      pop;
    logic [DW-1:0]   data_vec [2];
    logic [DW-1:0]   buf_reg  [2];
    logic            last_grant_reg;
    logic            mux_sel_reg;

    assign valid_vec   = {req1_valid, req0_valid};
    assign data_vec[0] = req0_data;
    assign data_vec[1] = req1_data;

    // Ready is the registered empty flag, forced low while reset is held.
    assign req0_ready = ~full_reg[0] & ~rst;
    assign req1_ready = ~full_reg[1] & ~rst;

    assign mux_in0   = buf_reg[0];
    assign mux_in1   = buf_reg[1];
    assign mux_sel   = mux_sel_reg;
    assign out_valid = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign accept[gi] = valid_vec[gi] & ~full_reg[gi];

            // A popped buffer only reopens on the following edge (no pass-through).
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_reg[gi] <= 1'b0;
                    buf_reg[gi]  <= '0;
                end else begin
                    if (pop[gi]) begin
                        full_reg[gi] <= 1'b0;
                    end else if (accept[gi]) begin
                        full_reg[gi] <= 1'b1;
                    end
                    if (accept[gi]) begin
                        buf_reg[gi] <= data_vec[gi];
                    end
                end
            end
        end
    endgenerate

`ifdef MUX_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_reg [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (pop[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign grant0_cnt = cnt_reg[0];
    assign grant1_cnt = cnt_reg[1];
`endif

    always_comb begin
        state_next = state_reg;
        pop        = 2'b00;
        case (state_reg)
            IDLE: begin
                // On a tie the channel that did not win last time goes first.
                if (full_reg[0] && full_reg[1]) begin
                    state_next = last_grant_reg ? GRANT0 : GRANT1;
                end else if (full_reg[0]) begin
                    state_next = GRANT0;
                end else if (full_reg[1]) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (out_ready) begin
                    pop[0]     = 1'b1;
                    state_next = full_reg[1] ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (out_ready) begin
                    pop[1]     = 1'b1;
                    state_next = full_reg[0] ? GRANT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mux_sel tracks the next grant so it is registered yet aligned with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            mux_sel_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pop[0]) begin
                last_grant_reg <= 1'b0;
            end else if (pop[1]) begin
                last_grant_reg <= 1'b1;
            end
            if (state_next == GRANT1) begin
                mux_sel_reg <= 1'b1;
            end else if (state_next == GRANT0) begin
                mux_sel_reg <= 1'b0;
            end
        end
    end

endmodule
